// File: rtl/step_dir_decoder.sv
`timescale 1ns/1ps
// STEP/DIR decoder: synchronises an A4988-style STEP/DIR pair into a signed position count with width/setup checks.
// Latency: step_valid and the position update land on the third clock edge after step_in is first sampled high.
// No backpressure: every rise is accepted; timing violations only raise sticky flags until clr or reset.
module step_dir_decoder #(
  parameter int POS_W     = 16,
  parameter int MIN_HIGH  = 50,
  parameter int MIN_LOW   = 50,
  parameter int DIR_SETUP = 10
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    clr,
  output logic signed [POS_W-1:0] position,
  output logic                    step_valid,
  output logic                    step_dir,
  output logic                    err_low,
  output logic                    err_high,
  output logic                    err_setup
);

  localparam int LW = $clog2(MIN_LOW + 1);
  localparam int HW = $clog2(MIN_HIGH + 1);
  localparam int DW = $clog2(DIR_SETUP + 1);

  typedef enum logic {ST_LOW, ST_HIGH} state_e;

  state_e                  state_q, state_d;
  logic signed [POS_W-1:0] position_q, position_d;
  logic                    step_valid_q, step_valid_d;
  logic                    step_dir_q, step_dir_d;
  logic                    err_low_q, err_low_d;
  logic                    err_high_q, err_high_d;
  logic                    err_setup_q, err_setup_d;
  logic [LW-1:0]           low_cnt_q, low_cnt_d;
  logic [HW-1:0]           high_cnt_q, high_cnt_d;
  logic [DW-1:0]           dir_cnt_q, dir_cnt_d;

  logic                    step_s1_q, step_s_q;
  logic                    dir_s1_q, dir_s_q;
  logic [1:0]              sync_rdy_q;
  logic                    dir_chg;

  // The first dir_s transition after reset is just the synchroniser filling from
  // its reset value, not a real direction change, so it must not restart dir_cnt.
  assign dir_chg = sync_rdy_q[1] && (dir_s1_q != dir_s_q);

  // Two-flop synchronisers plus a marker that tracks when they hold real samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      step_s1_q  <= 1'b0;
      step_s_q   <= 1'b0;
      dir_s1_q   <= 1'b0;
      dir_s_q    <= 1'b0;
      sync_rdy_q <= 2'b00;
    end else begin
      step_s1_q  <= step_in;
      step_s_q   <= step_s1_q;
      dir_s1_q   <= dir_in;
      dir_s_q    <= dir_s1_q;
      sync_rdy_q <= {sync_rdy_q[0], 1'b1};
    end
  end

  // FSM state, counters, position and flags register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOW;
      position_q   <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      err_low_q    <= 1'b0;
      err_high_q   <= 1'b0;
      err_setup_q  <= 1'b0;
      low_cnt_q    <= LW'(MIN_LOW);
      high_cnt_q   <= '0;
      dir_cnt_q    <= DW'(DIR_SETUP);
    end else begin
      state_q      <= state_d;
      position_q   <= position_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      err_low_q    <= err_low_d;
      err_high_q   <= err_high_d;
      err_setup_q  <= err_setup_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      dir_cnt_q    <= dir_cnt_d;
    end
  end

  // Next-state: edge detection via the FSM, width/setup checks, position update, clr override.
  always_comb begin
    state_d      = state_q;
    position_d   = position_q;
    step_valid_d = 1'b0;
    step_dir_d   = step_dir_q;
    err_low_d    = err_low_q;
    err_high_d   = err_high_q;
    err_setup_d  = err_setup_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    dir_cnt_d    = dir_cnt_q;

    // Direction age runs in both states; a change during HIGH only restarts it.
    if (dir_chg) begin
      dir_cnt_d = '0;
    end else if (dir_cnt_q != DW'(DIR_SETUP)) begin
      dir_cnt_d = dir_cnt_q + DW'(1);
    end

    case (state_q)
      ST_LOW: begin
        if (step_s_q) begin
          state_d      = ST_HIGH;
          high_cnt_d   = '0;
          step_valid_d = 1'b1;
          step_dir_d   = dir_s_q;
          position_d   = dir_s_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
          if (low_cnt_q < LW'(MIN_LOW)) err_low_d = 1'b1;
          if (dir_cnt_q < DW'(DIR_SETUP)) err_setup_d = 1'b1;
        end else if (low_cnt_q != LW'(MIN_LOW)) begin
          low_cnt_d = low_cnt_q + LW'(1);
        end
      end
      ST_HIGH: begin
        if (!step_s_q) begin
          state_d   = ST_LOW;
          low_cnt_d = '0;
          if (high_cnt_q < HW'(MIN_HIGH)) err_high_d = 1'b1;
        end else if (high_cnt_q != HW'(MIN_HIGH)) begin
          high_cnt_d = high_cnt_q + HW'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase

    // clr wins over a coincident step or violation, but the step pulse and direction still go out.
    if (clr) begin
      position_d  = '0;
      err_low_d   = 1'b0;
      err_high_d  = 1'b0;
      err_setup_d = 1'b0;
    end
  end

  assign position   = position_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign err_low    = err_low_q;
  assign err_high   = err_high_q;
  assign err_setup  = err_setup_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for step_dir_decoder: vector table of single pulses plus hand-written corner sequences.
module tb_step_dir_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_in;
  logic        dir_in;
  logic        clr;
  logic [15:0] position;
  logic        step_valid;
  logic        step_dir;
  logic        err_low;
  logic        err_high;
  logic        err_setup;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0;

  step_dir_decoder #(
    .POS_W(16), .MIN_HIGH(50), .MIN_LOW(50), .DIR_SETUP(10)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .step_in   (step_in),
    .dir_in    (dir_in),
    .clr       (clr),
    .position  (position),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .err_low   (err_low),
    .err_high  (err_high),
    .err_setup (err_setup)
  );

  always #10 clk = ~clk;

  // Count every clock that step_valid is high, so a stretched pulse shows up as an extra step.
  always @(negedge clk) begin
    if (step_valid === 1'b1) sv_cnt <= sv_cnt + 1;
  end

  typedef struct packed {
    logic        do_clr;
    logic        dir;
    int          lead;
    int          hi;
    int          lo;
    logic [15:0] pos;
    logic        sdir;
    logic        el;
    logic        eh;
    logic        es;
  } vec_t;

  vec_t vecs [10];

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_pulse(input int hi, input int lo);
    step_in = 1'b1;
    clk_n(hi);
    step_in = 1'b0;
    clk_n(lo);
  endtask

  initial begin
    int base;

    //            clr   dir   lead hi  lo  pos       sdir  el    eh    es
    vecs[0] = '{1'b0, 1'b1, 12, 60, 60, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 12, 60, 60, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12, 60, 60, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 12, 60, 60, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 12, 20, 18, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 12, 60, 60, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0,  4, 60, 60, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 12, 60, 60, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 12, 55, 55, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 12, 45, 60, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    reset   = 1'b1;
    step_in = 1'b0;
    dir_in  = 1'b1;
    clr     = 1'b0;
    clk_n(3);
    chk("rst position",   position,   16'h0000);
    chk("rst step_valid", step_valid, 1'b0);
    chk("rst step_dir",   step_dir,   1'b0);
    chk("rst err_low",    err_low,    1'b0);
    chk("rst err_high",   err_high,   1'b0);
    chk("rst err_setup",  err_setup,  1'b0);
    reset = 1'b0;
    clk_n(5);
    chk("idle step_valid", step_valid, 1'b0);
    chk("idle sv_cnt", sv_cnt, 0);

    // Table-driven single pulses; error flags are sticky, so expectations are cumulative.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_clr) begin
        clr = 1'b1;
        clk_n(1);
        clr = 1'b0;
      end
      dir_in = vecs[i].dir;
      clk_n(vecs[i].lead);
      base = sv_cnt;
      do_pulse(vecs[i].hi, vecs[i].lo);
      chk($sformatf("v%0d position", i),  position,     vecs[i].pos);
      chk($sformatf("v%0d step_dir", i),  step_dir,     vecs[i].sdir);
      chk($sformatf("v%0d err_low", i),   err_low,      vecs[i].el);
      chk($sformatf("v%0d err_high", i),  err_high,     vecs[i].eh);
      chk($sformatf("v%0d err_setup", i), err_setup,    vecs[i].es);
      chk($sformatf("v%0d pulses", i),    sv_cnt - base, 1);
    end

    // clr on the same edge as step_valid, with a setup violation on that edge too.
    dir_in = 1'b0;
    clk_n(4);
    base = sv_cnt;
    step_in = 1'b1;
    clk_n(2);
    clr = 1'b1;
    clk_n(1);
    clr = 1'b0;
    chk("clr step_valid", step_valid, 1'b1);
    chk("clr position",   position,   16'h0000);
    chk("clr step_dir",   step_dir,   1'b0);
    chk("clr err_low",    err_low,    1'b0);
    chk("clr err_high",   err_high,   1'b0);
    chk("clr err_setup",  err_setup,  1'b0);
    clk_n(1);
    chk("clr pulse width", step_valid, 1'b0);
    clk_n(57);
    step_in = 1'b0;
    clk_n(60);
    chk("clr after position", position, 16'h0000);
    chk("clr after errors", {err_low, err_high, err_setup}, 3'b000);
    chk("clr after pulses", sv_cnt - base, 1);

    // Positive wrap: run up to 0x7FFF with back-to-back 1/1 pulses, then one clean step.
    clr = 1'b1;
    clk_n(1);
    clr = 1'b0;
    dir_in = 1'b1;
    clk_n(12);
    base = sv_cnt;
    repeat (32767) begin
      step_in = 1'b1;
      clk_n(1);
      step_in = 1'b0;
      clk_n(1);
    end
    clk_n(60);
    chk("run position", position, 16'h7FFF);
    chk("run pulses", sv_cnt - base, 32767);
    do_pulse(60, 60);
    chk("wrap position", position, 16'h8000);
    chk("wrap step_dir", step_dir, 1'b1);

    // Reset during a 100-clock high pulse: asserted at clock 20, released at clock 40.
    step_in = 1'b1;
    clk_n(20);
    reset = 1'b1;
    clk_n(1);
    chk("midrst position", position, 16'h0000);
    chk("midrst errors", {err_low, err_high, err_setup}, 3'b000);
    chk("midrst step_dir", step_dir, 1'b0);
    clk_n(19);
    reset = 1'b0;
    base = sv_cnt;
    clk_n(60);
    step_in = 1'b0;
    clk_n(60);
    chk("postrst position", position, 16'h0001);
    chk("postrst step_dir", step_dir, 1'b1);
    chk("postrst err_low",   err_low,   1'b0);
    chk("postrst err_high",  err_high,  1'b0);
    chk("postrst err_setup", err_setup, 1'b0);
    chk("postrst pulses", sv_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
